// File: rtl/sr_mem_pkg.sv
// ============================================================================
// Module   : sr_mem_pkg
// Brief    : Shared state encoding and default limits for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_mem_pkg;

    localparam int unsigned c_starve_max_default = 4;
    localparam int unsigned c_timeout_default    = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sr_mem_timer.sv
// ============================================================================
// Module   : sr_mem_timer
// Brief    : Wait-cycle counter that flags expiry when the count hits TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_mem_timer
    import sr_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_timeout_default
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned          c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign expired = (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/sr_mem_arbiter.sv
// ============================================================================
// Module   : sr_mem_arbiter
// Brief    : Two-port (fetch/data) arbiter onto a single memory port, one
//            transaction outstanding, D-priority with I starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_mem_arbiter
    import sr_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = c_starve_max_default,
    parameter int unsigned TIMEOUT    = c_timeout_default
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_rdy,
    output logic        busy
);

    localparam int unsigned        c_sv_w         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_sv_w-1:0]  c_starve_limit = c_sv_w'(STARVE_MAX);

    state_t             r_state;
    state_t             w_next;
    logic [c_sv_w-1:0]  r_starve;
    logic               r_owner_i;
    logic               r_resp_err;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done;
    logic               w_timeout;
    logic               w_expired;

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // D wins unless the fetch side has been passed over STARVE_MAX times
                if (d_req && !(i_req && (r_starve == c_starve_limit))) begin
                    w_grant_d = 1'b1;
                    w_next    = ST_BUSY_D;
                end else if (i_req) begin
                    w_grant_i = 1'b1;
                    w_next    = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // A response arriving on the expiry cycle takes precedence
                if (m_rdy) begin
                    w_done = 1'b1;
                    w_next = ST_RESP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_starve   <= '0;
            r_owner_i  <= 1'b0;
            r_resp_err <= 1'b0;
            m_we       <= 1'b0;
            m_be       <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_starve  <= '0;
                r_owner_i <= 1'b1;
                m_we      <= 1'b0;
                m_be      <= 4'hF;
                m_addr    <= i_addr;
                m_wdata   <= '0;
            end
            if (w_grant_d) begin
                if (i_req && (r_starve != c_starve_limit)) begin
                    r_starve <= r_starve + c_sv_w'(1);
                end
                r_owner_i <= 1'b0;
                m_we      <= d_we;
                m_be      <= d_be;
                m_addr    <= d_addr;
                m_wdata   <= d_wdata;
            end
            if (w_done || w_timeout) begin
                r_resp_err <= w_timeout;
                if (r_owner_i) begin
                    i_rdata <= w_done ? m_rdata : '0;
                end else begin
                    d_rdata <= w_done ? m_rdata : '0;
                end
            end
        end
    end

    sr_mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_grant_i | w_grant_d),
        .enable  (m_req & ~m_rdy),
        .expired (w_expired)
    );

    assign busy  = (r_state != ST_IDLE);
    assign m_req = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    assign i_ack = (r_state == ST_RESP) &&  r_owner_i && !r_resp_err;
    assign i_err = (r_state == ST_RESP) &&  r_owner_i &&  r_resp_err;
    assign d_ack = (r_state == ST_RESP) && !r_owner_i && !r_resp_err;
    assign d_err = (r_state == ST_RESP) && !r_owner_i &&  r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_sr_mem_arbiter.sv
// ============================================================================
// Module   : tb_sr_mem_arbiter
// Brief    : Directed self-checking bench with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_mem_arbiter;

    localparam logic [3:0] c_k_i_ack = 4'b1000;
    localparam logic [3:0] c_k_i_err = 4'b0100;
    localparam logic [3:0] c_k_d_ack = 4'b0010;

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdy;
    logic        busy;

    int   checks;
    int   errors;
    int   resp_count;
    int   n_push;
    exp_t sb[$];

    sr_mem_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_rdy   (m_rdy),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] kind, input logic [31:0] data, input bit chk_data);
        exp_t e;
        e.kind     = kind;
        e.data     = data;
        e.chk_data = chk_data;
        sb.push_back(e);
        n_push++;
    endtask

    // Response monitor: every ack/err pulse is matched against the next expectation
    always @(negedge clk) begin
        if (i_ack || i_err || d_ack || d_err) begin
            exp_t e;
            resp_count++;
            chk("sb_expected_response", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_kind", 32'({i_ack, i_err, d_ack, d_err}), 32'(e.kind));
                if (e.chk_data) begin
                    if (e.kind[3] || e.kind[2]) chk("i_rdata", i_rdata, e.data);
                    else                        chk("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    initial begin
        int rc;
        int n;
        bit is_i;
        logic [31:0] dat;

        checks = 0; errors = 0; resp_count = 0; n_push = 0;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_rdy = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_acks", 32'({i_ack, i_err, d_ack, d_err}), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_we_be", 32'({m_we, m_be}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // m_rdy while idle must be ignored
        rst_n = 1'b1;
        m_rdy = 1'b1;
        tick(); tick();
        chk("idle_rdy_busy", 32'(busy), 32'd0);

        // Single fetch, minimum latency
        i_req = 1'b1; i_addr = 32'h100; m_rdata = 32'h0050_0093;
        push(c_k_i_ack, 32'h0050_0093, 1'b1);
        tick();
        chk("fetch_m_req", 32'(m_req), 32'd1);
        chk("fetch_m_addr", m_addr, 32'h100);
        chk("fetch_we_be", 32'({m_we, m_be}), 32'h0F);
        tick();
        chk("fetch_ack_cycle2", 32'(i_ack), 32'd1);
        tick();
        i_req = 1'b0;
        chk("fetch_busy_cycle3", 32'(busy), 32'd0);

        // Both requesting continuously: D,D,D,D,I repeated
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
        for (int k = 0; k < 10; k++) begin
            is_i = ((k % 5) == 4);
            dat = 32'h5000_0000 + 32'(k);
            m_rdata = dat;
            push(is_i ? c_k_i_ack : c_k_d_ack, dat, 1'b1);
            tick();
            chk("arb_m_req", 32'(m_req), 32'd1);
            chk("arb_order_addr", m_addr, is_i ? 32'h1000 : 32'h2000);
            tick();
            if (k == 9) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
        end

        // Store with five wait cycles; request dropped early, fields held
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hCAFE_BABE;
        m_rdy = 1'b0;
        push(c_k_d_ack, 32'h0, 1'b0);
        tick();
        for (int j = 0; j < 6; j++) begin
            m_rdy = (j == 5);
            chk("st_m_req", 32'(m_req), 32'd1);
            chk("st_m_we_be", 32'({m_we, m_be}), 32'h13);
            chk("st_m_addr", m_addr, 32'h2000);
            chk("st_m_wdata", m_wdata, 32'hCAFE_BABE);
            if (j == 1) begin
                d_req = 1'b0;
                d_addr = 32'hDEAD_0000;
                d_wdata = 32'h0;
            end
            tick();
        end
        m_rdy = 1'b0; d_we = 1'b0;
        tick();

        // Timeout: no m_rdy at all
        i_req = 1'b1; i_addr = 32'h300; m_rdy = 1'b0; m_rdata = 32'hFFFF_FFFF;
        push(c_k_i_err, 32'h0, 1'b1);
        tick();
        n = 0;
        while (m_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("timeout_busy_cycles", 32'(n), 32'd256);
        i_req = 1'b0;
        tick();

        // m_rdy on the expiry cycle wins
        i_req = 1'b1; i_addr = 32'h400;
        push(c_k_i_ack, 32'h1234_5678, 1'b1);
        tick();
        repeat (255) tick();
        m_rdy = 1'b1; m_rdata = 32'h1234_5678;
        chk("edge_m_req", 32'(m_req), 32'd1);
        tick();
        i_req = 1'b0; m_rdy = 1'b0;
        tick();

        // Reset in the middle of a data transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        tick(); tick();
        chk("mid_m_req", 32'(m_req), 32'd1);
        rc = resp_count;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_m_req", 32'(m_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_m_addr", m_addr, 32'd0);
        rst_n = 1'b1; d_req = 1'b0;
        tick(); tick();
        chk("mid_rst_no_resp", 32'(resp_count), 32'(rc));

        i_req = 1'b1; i_addr = 32'h600; m_rdy = 1'b1; m_rdata = 32'hBEEF_0001;
        push(c_k_i_ack, 32'hBEEF_0001, 1'b1);
        tick();
        chk("post_rst_m_addr", m_addr, 32'h600);
        tick();
        i_req = 1'b0; m_rdy = 1'b0;
        tick(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("resp_total", 32'(resp_count), 32'(n_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_mem_arbiter.md
SR_MEM_ARBITER -- requirements
Module: sr_mem_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_MAX, default 4, max consecutive D grants while I is pending; TIMEOUT, default 255, max wait cycles for m_rdy.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 i_req  in  1  fetch request, held high until i_ack or i_err; i_addr  in  32  fetch address.
REQ-005 i_rdata  out  32  fetch data, valid while i_ack=1; i_ack  out  1  fetch complete pulse; i_err  out  1  fetch timeout pulse.
REQ-006 d_req  in  1  data request; d_we  in  1  1=store; d_be  in  4  byte enables; d_addr  in  32  address; d_wdata  in  32  store data.
REQ-007 d_rdata  out  32  load data, valid while d_ack=1; d_ack  out  1  data complete pulse; d_err  out  1  data timeout pulse.
REQ-008 m_req  out  1  memory request; m_we  out  1; m_be  out  4; m_addr  out  32; m_wdata  out  32; m_rdata  in  32; m_rdy  in  1  memory done, m_rdata valid.
REQ-009 busy  out  1  high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP; one transaction outstanding at a time.
REQ-011 IDLE: if only i_req, go to BUSY_I; if only d_req, go to BUSY_D; if neither, stay in IDLE.
REQ-012 IDLE with i_req and d_req: grant D unless starve_cnt==STARVE_MAX, in which case grant I.
REQ-013 starve_cnt: +1 on each D grant made while i_req=1; cleared on any I grant; saturates at STARVE_MAX.
REQ-014 On grant, m_we/m_be/m_addr/m_wdata SHALL be registered from the winner; I grants drive m_we=0 and m_be=4'hF.
REQ-015 m_req=1 in BUSY_I/BUSY_D only; address, be, we and wdata are held stable until exit; m_req rises one cycle after the IDLE sampling cycle.
REQ-016 BUSY_x with m_rdy=1: register m_rdata into x_rdata and go to RESP, giving ack for x.
REQ-017 RESP: x_ack=1 for exactly one cycle with x_rdata valid; next state is IDLE; requests are not sampled in RESP.
REQ-018 Minimum latency: req seen in IDLE at cycle 0, m_req at cycle 1, m_rdy at cycle 1, ack at cycle 2; issue-to-issue is 3 cycles.
REQ-019 Requester SHALL drop req at the edge where it samples ack or err; req dropped early has no effect on the active transaction.
REQ-020 Wait counter: cleared on grant; +1 each BUSY cycle with m_rdy=0; at count==TIMEOUT, go to RESP with x_err=1 instead of x_ack, and x_rdata=0.
REQ-021 m_rdy in the same cycle the count reaches TIMEOUT SHALL win: ack, no err.
REQ-022 m_rdy outside BUSY states SHALL be ignored.
REQ-023 x_ack and x_err SHALL be mutually exclusive; at most one requester is acked per cycle.
REQ-024 d_rdata for a store ack SHALL be whatever m_rdata holds and is don't-care for requesters.

Reset
REQ-025 rst_n=0 SHALL force state IDLE, starve_cnt=0, wait counter=0, and every output to 0, including all data/address buses.
REQ-026 Reset mid-transaction SHALL drop m_req at the next edge with no ack or err issued; first post-reset grant follows REQ-011/012.

Structure
REQ-027 Shared package sr_mem_pkg SHALL hold the state enum and the STARVE_MAX/TIMEOUT default constants.
REQ-028 Wait counter with timeout compare SHALL be one sub-module, sr_mem_timer (clear, enable, expired).
REQ-029 Arbitration, FSM and registers SHALL stay in sr_mem_arbiter; no combinational path from m_rdy to any output.

Verification
REQ-030 Single fetch i_addr=0x100, m_rdy in first BUSY cycle, m_rdata=0x00500093 -> i_ack at cycle 2, i_rdata=0x00500093, busy low at cycle 3.
REQ-031 Both reqs held continuously, m_rdy always 1 -> grant order D,D,D,D,I,D..., starve_cnt cleared after the I grant.
REQ-032 Store d_addr=0x2000, d_be=4'b0011, d_wdata=0xCAFEBABE, m_rdy after 5 wait cycles -> m_we=1 and fields stable for all 6 BUSY cycles, then one d_ack.
REQ-033 m_rdy never asserted, TIMEOUT=255 -> i_err one pulse after 255 wait cycles, i_rdata=0, no i_ack.
REQ-034 m_rdy in the same cycle as the timeout count -> ack only, no err.
REQ-035 rst_n low during BUSY_D -> next cycle m_req=0, busy=0, no d_ack; a following i_req is served normally.
